// File: rtl/fsmc_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// fsmc_bus_master_pkg
// Shared definitions for the FSMC-style asynchronous SRAM bus master:
//   - access-sequencer state encoding
//   - minimum legal phase lengths and the largest count a phase can hold
//   - width of the shared phase down-counter
// No ports (package).
// ---------------------------------------------------------------------------
package fsmc_bus_master_pkg;

  localparam int CNT_W      = 8;
  localparam int PHASE_MAX  = 255;
  localparam int ADDSET_MIN = 1;
  localparam int DATAST_MIN = 2;
  localparam int HOLD_MIN   = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_HOLD = 3'd3,
    ST_TURN = 3'd4
  } state_t;

endpackage

// File: rtl/fsmc_bus_master_if.sv
// ---------------------------------------------------------------------------
// fsmc_bus_master_if
// Bundles the fabric request/response handshake and the external bus pins.
//   Request : req_valid, req_ready, req_write, req_adr, req_wdata
//   Response: rsp_valid, rsp_rdata
//   Bus     : NE, NOE, NWE (active-low), A, D_out, D_oe, D_in
// modport master: the bus master block itself.
// modport slave : whatever sits opposite (fabric requester + bus target).
// ---------------------------------------------------------------------------
interface fsmc_bus_master_if #(
  parameter int ADRW = 8,
  parameter int DATW = 16
);

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADRW-1:0] req_adr;
  logic [DATW-1:0] req_wdata;
  logic            rsp_valid;
  logic [DATW-1:0] rsp_rdata;
  logic            NE;
  logic            NOE;
  logic            NWE;
  logic [ADRW-1:0] A;
  logic [DATW-1:0] D_out;
  logic            D_oe;
  logic [DATW-1:0] D_in;

  modport master (
    input  req_valid, req_write, req_adr, req_wdata, D_in,
    output req_ready, rsp_valid, rsp_rdata, NE, NOE, NWE, A, D_out, D_oe
  );

  modport slave (
    output req_valid, req_write, req_adr, req_wdata, D_in,
    input  req_ready, rsp_valid, rsp_rdata, NE, NOE, NWE, A, D_out, D_oe
  );

endinterface

// File: rtl/fsmc_phase_timer.sv
// ---------------------------------------------------------------------------
// fsmc_phase_timer
// Down-counter shared by every bus phase. Loading N-1 makes 'last' high on
// the N-th cycle after the load edge, so a phase of N cycles ends on the
// edge where 'last' is seen high.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val on the next edge (takes priority)
//   load_val  : count to load
//   last      : high while the count is zero (final cycle of the phase)
// ---------------------------------------------------------------------------
module fsmc_phase_timer
  import fsmc_bus_master_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Count register: load wins, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/fsmc_bus_master.sv
// ---------------------------------------------------------------------------
// fsmc_bus_master
// Initiator for an FSMC mode-1 style asynchronous SRAM bus. Each accepted
// single-word request becomes one NE/NOE/NWE cycle: address setup, strobe,
// hold and optional bus turnaround, each lasting a parameterised number of
// clocks. All bus outputs are registered; req_ready is decoded from IDLE.
//   clk, rst : fabric clock, synchronous active-high reset
//   bus      : fsmc_bus_master_if.master (request, response and bus pins)
// Parameters: ADRW, DATW, ADDSET (1..255), DATAST (2..255), HOLD (1..255),
//             TURN (0..255).
// ---------------------------------------------------------------------------
module fsmc_bus_master
  import fsmc_bus_master_pkg::*;
#(
  parameter int ADRW   = 8,
  parameter int DATW   = 16,
  parameter int ADDSET = 2,
  parameter int DATAST = 6,
  parameter int HOLD   = 1,
  parameter int TURN   = 1
) (
  input logic               clk,
  input logic               rst,
  fsmc_bus_master_if.master bus
);

  // Reject timing parameters that the sequencer cannot honour.
  if (ADDSET < ADDSET_MIN || ADDSET > PHASE_MAX) begin : g_bad_addset
    $error("fsmc_bus_master: ADDSET out of range");
  end
  if (DATAST < DATAST_MIN || DATAST > PHASE_MAX) begin : g_bad_datast
    $error("fsmc_bus_master: DATAST out of range");
  end
  if (HOLD < HOLD_MIN || HOLD > PHASE_MAX) begin : g_bad_hold
    $error("fsmc_bus_master: HOLD out of range");
  end
  if (TURN < 0 || TURN > PHASE_MAX) begin : g_bad_turn
    $error("fsmc_bus_master: TURN out of range");
  end

  state_t            state, state_n;
  logic              ne_q, ne_n;
  logic              noe_q, noe_n;
  logic              nwe_q, nwe_n;
  logic [ADRW-1:0]   a_q, a_n;
  logic [DATW-1:0]   dout_q, dout_n;
  logic              doe_q, doe_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [DATW-1:0]   rdata_q, rdata_n;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_last;

  fsmc_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  // Next-state and next-output decode. D_oe stays equal to the request's
  // write flag from accept until the end of HOLD, so it doubles as the
  // access direction while the strobe is being chosen and released.
  always_comb begin
    state_n     = state;
    ne_n        = ne_q;
    noe_n       = noe_q;
    nwe_n       = nwe_q;
    a_n         = a_q;
    dout_n      = dout_q;
    doe_n       = doe_q;
    rsp_valid_n = 1'b0;
    rdata_n     = rdata_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          a_n      = bus.req_adr;
          dout_n   = bus.req_wdata;
          doe_n    = bus.req_write;
          ne_n     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ADDSET - 1);
          state_n  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (tmr_last) begin
          if (doe_q) begin
            nwe_n = 1'b0;
          end else begin
            noe_n = 1'b0;
          end
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DATAST - 1);
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        // D_in is taken raw: DATAST is chosen to cover the target's access
        // time, so the data has settled well before this edge.
        if (tmr_last) begin
          noe_n       = 1'b1;
          nwe_n       = 1'b1;
          rsp_valid_n = 1'b1;
          if (!doe_q) begin
            rdata_n = bus.D_in;
          end
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD - 1);
          state_n  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_last) begin
          ne_n  = 1'b1;
          doe_n = 1'b0;
          if (TURN == 0) begin
            state_n = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(TURN - 1);
            state_n  = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        if (tmr_last) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered bus outputs. Reset drops any access in flight:
  // strobes and NE go high, the data driver turns off, no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ne_q        <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      a_q         <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_n;
      ne_q        <= ne_n;
      noe_q       <= noe_n;
      nwe_q       <= nwe_n;
      a_q         <= a_n;
      dout_q      <= dout_n;
      doe_q       <= doe_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.NE        = ne_q;
  assign bus.NOE       = noe_q;
  assign bus.NWE       = nwe_q;
  assign bus.A         = a_q;
  assign bus.D_out     = dout_q;
  assign bus.D_oe      = doe_q;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// ---------------------------------------------------------------------------
// tb_fsmc_bus_master
// Directed bench for fsmc_bus_master. dut0 uses the default timing
// (2/6/1/1), dut1 the fastest legal timing (1/2/1/0). Shared request
// variables feed both; 'sel' picks which one receives req_valid and which
// one the m_* monitor wires look at. A small behavioural bus target with
// four mapped words serves the loopback part.
// ---------------------------------------------------------------------------
module tb_fsmc_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [7:0]  req_adr;
  logic [15:0] req_wdata;
  logic        sel;
  logic        slave_mode;
  logic [15:0] din_value;

  int pass_cnt;
  int total_cnt;

  fsmc_bus_master_if #(.ADRW(8), .DATW(16)) b0 ();
  fsmc_bus_master_if #(.ADRW(8), .DATW(16)) b1 ();

  fsmc_bus_master #(
    .ADRW(8), .DATW(16), .ADDSET(2), .DATAST(6), .HOLD(1), .TURN(1)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  fsmc_bus_master #(
    .ADRW(8), .DATW(16), .ADDSET(1), .DATAST(2), .HOLD(1), .TURN(0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor view of whichever DUT is selected.
  logic        m_ready, m_rsp, m_ne, m_noe, m_nwe, m_doe;
  logic [7:0]  m_a;
  logic [15:0] m_dout, m_rdata;

  assign m_ready = sel ? b1.req_ready : b0.req_ready;
  assign m_rsp   = sel ? b1.rsp_valid : b0.rsp_valid;
  assign m_rdata = sel ? b1.rsp_rdata : b0.rsp_rdata;
  assign m_ne    = sel ? b1.NE        : b0.NE;
  assign m_noe   = sel ? b1.NOE       : b0.NOE;
  assign m_nwe   = sel ? b1.NWE       : b0.NWE;
  assign m_a     = sel ? b1.A         : b0.A;
  assign m_dout  = sel ? b1.D_out     : b0.D_out;
  assign m_doe   = sel ? b1.D_oe      : b0.D_oe;

  // Behavioural bus target: words at 6, 100, 60 and 255; everything else
  // reads as zero. Data is only driven while NOE is low.
  logic [15:0] mem [256];
  logic [15:0] slave_rdata;
  logic [15:0] din_bus;

  function automatic logic mapped(input logic [7:0] a);
    return (a == 8'd6) || (a == 8'd100) || (a == 8'd60) || (a == 8'd255);
  endfunction

  // Target write port: capture D_out while NE and NWE are both low.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
    end else if (!m_ne && !m_nwe && mapped(m_a)) begin
      mem[m_a] <= m_dout;
    end
  end

  assign slave_rdata = mapped(m_a) ? mem[m_a] : 16'h0000;
  assign din_bus     = !m_noe ? (slave_mode ? slave_rdata : din_value) : 16'h0000;

  assign b0.req_valid = req_valid && !sel;
  assign b1.req_valid = req_valid && sel;
  assign b0.req_write = req_write;
  assign b1.req_write = req_write;
  assign b0.req_adr   = req_adr;
  assign b1.req_adr   = req_adr;
  assign b0.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b0.D_in      = din_bus;
  assign b1.D_in      = din_bus;

  // Per-access statistics, indexed by negedge number after the accept edge.
  int          ne_cnt, nwe_cnt, noe_cnt, doe_cnt, rsp_cnt;
  int          first_ne, first_stb, ready_at;
  int          bad_a, bad_d, overlap, stb_no_ne;
  logic [15:0] rdata_at_rsp;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access on the selected DUT, then 16 cycles of observation. With
  // 'scramble' set, the request inputs are changed mid-access.
  task automatic applyStimulus(input logic wr, input logic [7:0] adr,
                               input logic [15:0] wd, input bit scramble);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_adr   = adr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    ne_cnt = 0; nwe_cnt = 0; noe_cnt = 0; doe_cnt = 0; rsp_cnt = 0;
    first_ne = 0; first_stb = 0; ready_at = 0;
    bad_a = 0; bad_d = 0; overlap = 0; stb_no_ne = 0;
    rdata_at_rsp = 16'hDEAD;
    for (int i = 1; i <= 16; i++) begin
      if (scramble && i == 2) begin
        req_adr   = ~adr;
        req_wdata = ~wd;
        req_write = ~wr;
      end
      if (!m_ne) begin
        ne_cnt++;
        if (first_ne == 0) first_ne = i;
        if (m_a != adr) bad_a++;
        if (wr && m_dout != wd) bad_d++;
      end
      if (!m_nwe || !m_noe) begin
        if (first_stb == 0) first_stb = i;
        if (m_ne) stb_no_ne++;
      end
      if (!m_nwe) nwe_cnt++;
      if (!m_noe) noe_cnt++;
      if (!m_noe && !m_nwe) overlap++;
      if (m_doe) doe_cnt++;
      if (m_rsp) begin
        rsp_cnt++;
        rdata_at_rsp = m_rdata;
      end
      if (m_ready && ready_at == 0) ready_at = i;
      @(negedge clk);
    end
  endtask

  // Two requests with req_valid held high: a write, then a read.
  task automatic runBackToBack(input string pfx, input int exp_gap,
                               input int exp_ne_high);
    int n_acc, first, second, ne_high, ovl;
    bit seen_low;
    n_acc = 0; first = 0; second = 0; ne_high = 0; ovl = 0; seen_low = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_adr   = 8'h21;
    req_wdata = 16'h5A5A;
    for (int i = 0; i < 40; i++) begin
      if (n_acc == 2) req_valid = 1'b0;
      if (n_acc == 1) begin
        req_write = 1'b0;
        req_adr   = 8'h64;
      end
      if (m_ready && req_valid) begin
        n_acc++;
        if (n_acc == 1) first = i;
        else            second = i;
      end
      if (n_acc >= 1 && !m_ne) seen_low = 1'b1;
      if (seen_low && m_ne && (n_acc == 1 || i == second)) ne_high++;
      if (!m_noe && !m_nwe) ovl++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput({pfx, "_accepts"}, n_acc, 2);
    checkOutput({pfx, "_gap"}, second - first, exp_gap);
    checkOutput({pfx, "_ne_high"}, ne_high, exp_ne_high);
    checkOutput({pfx, "_overlap"}, ovl, 0);
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_adr    = 8'h00;
    req_wdata  = 16'h0000;
    sel        = 1'b0;
    slave_mode = 1'b0;
    din_value  = 16'h0000;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_ne",    b0.NE, 1);
    checkOutput("rst_noe",   b0.NOE, 1);
    checkOutput("rst_nwe",   b0.NWE, 1);
    checkOutput("rst_doe",   b0.D_oe, 0);
    checkOutput("rst_a",     b0.A, 0);
    checkOutput("rst_dout",  b0.D_out, 0);
    checkOutput("rst_rsp",   b0.rsp_valid, 0);
    checkOutput("rst_rdata", b0.rsp_rdata, 0);
    checkOutput("rst_ready", b0.req_ready, 1);
    rst = 1'b0;

    // Default-timing write: NE low 9, NWE low 6 starting 2 after NE falls.
    applyStimulus(1'b1, 8'h06, 16'hBEEF, 1'b0);
    checkOutput("wr_ne_cnt",    ne_cnt, 9);
    checkOutput("wr_nwe_cnt",   nwe_cnt, 6);
    checkOutput("wr_noe_cnt",   noe_cnt, 0);
    checkOutput("wr_stb_delay", first_stb - first_ne, 2);
    checkOutput("wr_doe_cnt",   doe_cnt, 9);
    checkOutput("wr_a",         bad_a, 0);
    checkOutput("wr_dout",      bad_d, 0);
    checkOutput("wr_rsp_cnt",   rsp_cnt, 1);
    checkOutput("wr_ready_at",  ready_at, 11);
    checkOutput("wr_stb_no_ne", stb_no_ne, 0);
    checkOutput("wr_rdata_keep", m_rdata, 16'h0000);

    // Default-timing read with the bench driving 1234 during the strobe.
    din_value = 16'h1234;
    applyStimulus(1'b0, 8'h64, 16'h0000, 1'b0);
    checkOutput("rd_noe_cnt",   noe_cnt, 6);
    checkOutput("rd_nwe_cnt",   nwe_cnt, 0);
    checkOutput("rd_doe_cnt",   doe_cnt, 0);
    checkOutput("rd_a",         bad_a, 0);
    checkOutput("rd_rsp_cnt",   rsp_cnt, 1);
    checkOutput("rd_rdata",     rdata_at_rsp, 16'h1234);
    checkOutput("rd_rdata_held", m_rdata, 16'h1234);

    // Back-to-back write then read. NE stays high through TURN plus the
    // IDLE cycle in which the next request is accepted.
    din_value = 16'h4321;
    runBackToBack("b2b", 11, 2);
    checkOutput("b2b_rdata", m_rdata, 16'h4321);

    // Reset on the 3rd DATA cycle of a read.
    din_value = 16'hCAFE;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_adr   = 8'h64;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_noe_low", m_noe, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_ne",    m_ne, 1);
    checkOutput("mid_noe",   m_noe, 1);
    checkOutput("mid_nwe",   m_nwe, 1);
    checkOutput("mid_doe",   m_doe, 0);
    checkOutput("mid_ready", m_ready, 1);
    checkOutput("mid_rdata", m_rdata, 16'h0000);
    rsp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_rsp) rsp_cnt++;
      @(negedge clk);
    end
    checkOutput("mid_no_rsp", rsp_cnt, 0);

    // Fastest timing on dut1, with request inputs disturbed mid-access.
    sel = 1'b1;
    applyStimulus(1'b1, 8'h3C, 16'hA5C3, 1'b1);
    checkOutput("fast_ne_cnt",   ne_cnt, 4);
    checkOutput("fast_nwe_cnt",  nwe_cnt, 2);
    checkOutput("fast_stb_dly",  first_stb - first_ne, 1);
    checkOutput("fast_a_stable", bad_a, 0);
    checkOutput("fast_d_stable", bad_d, 0);
    checkOutput("fast_ready_at", ready_at, 5);
    checkOutput("fast_rsp_cnt",  rsp_cnt, 1);
    runBackToBack("fast_b2b", 5, 1);
    sel = 1'b0;

    // Loopback against the behavioural target.
    slave_mode = 1'b1;
    applyStimulus(1'b1, 8'd6,   16'h1111, 1'b0);
    applyStimulus(1'b1, 8'd100, 16'h2222, 1'b0);
    applyStimulus(1'b1, 8'd60,  16'h3333, 1'b0);
    applyStimulus(1'b1, 8'd255, 16'h4444, 1'b0);
    applyStimulus(1'b0, 8'd6,   16'h0000, 1'b0);
    checkOutput("lb_rd_6",   rdata_at_rsp, 16'h1111);
    applyStimulus(1'b0, 8'd100, 16'h0000, 1'b0);
    checkOutput("lb_rd_100", rdata_at_rsp, 16'h2222);
    applyStimulus(1'b0, 8'd60,  16'h0000, 1'b0);
    checkOutput("lb_rd_60",  rdata_at_rsp, 16'h3333);
    applyStimulus(1'b0, 8'd255, 16'h0000, 1'b0);
    checkOutput("lb_rd_255", rdata_at_rsp, 16'h4444);
    applyStimulus(1'b0, 8'd7,   16'h0000, 1'b0);
    checkOutput("lb_rd_7",   rdata_at_rsp, 16'h0000);
    checkOutput("lb_rsp_7",  rsp_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
